// File: rtl/clk_rate_pkg.sv
// Shared types, default divisors and the divisor-table lookup for the clock-rate sequencer.
package clk_rate_pkg;

  localparam int SEL_W   = 2;
  localparam int NUM_SEL = 4;

  typedef enum logic {STOP = 1'b0, RUN = 1'b1} state_e;

  localparam logic [27:0] DIV_11HZ = 28'd9090909;
  localparam logic [27:0] DIV_1HZ  = 28'd100000000;
  localparam logic [27:0] DIV_2HZ  = 28'd50000000;
  localparam logic [27:0] DIV_5HZ  = 28'd20000000;

  // Entry n holds the divisor for sel == n.
  typedef logic [NUM_SEL-1:0][31:0] div_tbl_t;

  function automatic logic [31:0] div_of(input logic [SEL_W-1:0] sel, input div_tbl_t tbl);
    return tbl[sel];
  endfunction

endpackage

// File: rtl/clk_div_core.sv
// Divide counter producing clock_out and a period-start tick; periods start only on load.
module clk_div_core #(
  parameter int CNT_W = 28
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic [CNT_W-1:0] div,
  input  logic             run,
  input  logic             load,
  output logic             wrap,
  output logic             clock_out,
  output logic             tick
);

  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc, half;
  logic             clk_q, clk_d, tick_q, tick_d;

  assign half    = div >> 1;
  assign cnt_inc = cnt_q + CNT_W'(1);
  assign wrap    = run && (cnt_q == div - CNT_W'(1));

  // Anything that is neither a new period nor a mid-period count parks the counter low.
  always_comb begin
    cnt_d  = '0;
    clk_d  = 1'b0;
    tick_d = 1'b0;
    if (load) begin
      clk_d  = 1'b1;
      tick_d = 1'b1;
    end else if (run && !wrap) begin
      cnt_d = cnt_inc;
      clk_d = (cnt_inc < half);
    end
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign clock_out = clk_q;
  assign tick      = tick_q;

endmodule

// File: rtl/clk_rate_sequencer.sv
// Run/stop FSM and rate-change handshake around clk_div_core; rate changes land only on period boundaries.
module clk_rate_sequencer
  import clk_rate_pkg::*;
#(
  parameter int               CNT_W     = 28,
  parameter logic [CNT_W-1:0] DIV0      = CNT_W'(DIV_11HZ),
  parameter logic [CNT_W-1:0] DIV1      = CNT_W'(DIV_1HZ),
  parameter logic [CNT_W-1:0] DIV2      = CNT_W'(DIV_2HZ),
  parameter logic [CNT_W-1:0] DIV3      = CNT_W'(DIV_5HZ),
  parameter logic [SEL_W-1:0] RESET_SEL = 2'd0
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [SEL_W-1:0] sel,
  input  logic             sel_valid,
  output logic             sel_ready,
  output logic             clock_out,
  output logic             tick,
  output logic [SEL_W-1:0] active_sel,
  output logic             running
);

  if (CNT_W > 32 || DIV0 < CNT_W'(2) || DIV1 < CNT_W'(2) ||
      DIV2 < CNT_W'(2) || DIV3 < CNT_W'(2)) begin : g_bad_div
    $error("clk_rate_sequencer: divisors must be >= 2 and CNT_W <= 32");
  end

  localparam div_tbl_t DIV_TBL = {32'(DIV3), 32'(DIV2), 32'(DIV1), 32'(DIV0)};

  state_e           state_q, state_d;
  logic [SEL_W-1:0] active_sel_q, active_sel_d;
  logic [SEL_W-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             rdy_q;
  logic             running_q, running_d;
  logic             load, run, wrap, accept;
  logic [CNT_W-1:0] div;

  assign div    = CNT_W'(div_of(active_sel_q, DIV_TBL));
  assign run    = (state_q == RUN);
  assign accept = sel_valid && rdy_q;

  clk_div_core #(.CNT_W(CNT_W)) u_core (
    .clock_in  (clock_in),
    .reset_n   (reset_n),
    .div       (div),
    .run       (run),
    .load      (load),
    .wrap      (wrap),
    .clock_out (clock_out),
    .tick      (tick)
  );

  always_comb begin
    state_d      = state_q;
    active_sel_d = active_sel_q;
    pend_d       = pend_q;
    pend_vld_d   = pend_vld_q;
    running_d    = running_q;
    load         = 1'b0;
    case (state_q)
      STOP: begin
        // A request caught on the stop wrap is still pending here; drain it first.
        if (pend_vld_q) begin
          active_sel_d = pend_q;
          pend_vld_d   = 1'b0;
        end else if (accept) begin
          active_sel_d = sel;
        end
        if (enable) begin
          state_d   = RUN;
          running_d = 1'b1;
          load      = 1'b1;
        end
      end
      RUN: begin
        if (wrap) begin
          if (pend_vld_q) begin
            active_sel_d = pend_q;
            pend_vld_d   = 1'b0;
          end
          if (enable) begin
            load = 1'b1;
          end else begin
            state_d   = STOP;
            running_d = 1'b0;
          end
        end
        if (accept) begin
          pend_d     = sel;
          pend_vld_d = 1'b1;
        end
      end
      default: state_d = STOP;
    endcase
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= STOP;
      active_sel_q <= RESET_SEL;
      pend_q       <= '0;
      pend_vld_q   <= 1'b0;
      rdy_q        <= 1'b1;
      running_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      active_sel_q <= active_sel_d;
      pend_q       <= pend_d;
      pend_vld_q   <= pend_vld_d;
      rdy_q        <= !pend_vld_d;
      running_q    <= running_d;
    end
  end

  assign sel_ready  = rdy_q;
  assign active_sel = active_sel_q;
  assign running    = running_q;

endmodule

// File: tb/tb_clk_rate_sequencer.sv
// Directed bench for clk_rate_sequencer with small divisors (4, 6, 5, 2).
module tb_clk_rate_sequencer;

  logic       clock_in = 1'b0;
  logic       reset_n;
  logic       enable;
  logic [1:0] sel;
  logic       sel_valid;
  logic       sel_ready;
  logic       clock_out;
  logic       tick;
  logic [1:0] active_sel;
  logic       running;

  int n_chk = 0;
  int n_err = 0;

  clk_rate_sequencer #(
    .CNT_W     (28),
    .DIV0      (28'd4),
    .DIV1      (28'd6),
    .DIV2      (28'd5),
    .DIV3      (28'd2),
    .RESET_SEL (2'd0)
  ) dut (
    .clock_in   (clock_in),
    .reset_n    (reset_n),
    .enable     (enable),
    .sel        (sel),
    .sel_valid  (sel_valid),
    .sel_ready  (sel_ready),
    .clock_out  (clock_out),
    .tick       (tick),
    .active_sel (active_sel),
    .running    (running)
  );

  always #5 clock_in = ~clock_in;

  // Observed vector: {clock_out, tick, running, active_sel[1:0], sel_ready}
  logic [5:0] obs;
  assign obs = {clock_out, tick, running, active_sel, sel_ready};

  task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got {clk,tick,run,sel,rdy}=%b expected %b", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input logic [5:0] exp);
    @(posedge clock_in);
    @(negedge clock_in);
    chk(tag, obs, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; enable = 1'b0; sel = 2'd0; sel_valid = 1'b0;
    repeat (2) @(negedge clock_in);
    chk("reset", obs, 6'b0_0_0_00_1);
    reset_n = 1'b1;
    step("idle", 6'b0_0_0_00_1);

    // div 4: 1100 with a tick every 4 cycles
    enable = 1'b1;
    step("a_start", 6'b1_1_1_00_1);
    step("a_c1",    6'b1_0_1_00_1);
    step("a_c2",    6'b0_0_1_00_1);
    step("a_c3",    6'b0_0_1_00_1);
    step("a_wrap",  6'b1_1_1_00_1);

    // request sel=1 mid-period, applied at the wrap: 111000
    sel = 2'd1; sel_valid = 1'b1;
    step("b_acc",   6'b1_0_1_00_0);
    sel_valid = 1'b0;
    step("b_c2",    6'b0_0_1_00_0);
    step("b_c3",    6'b0_0_1_00_0);
    step("b_wrap",  6'b1_1_1_01_1);
    step("b_c1",    6'b1_0_1_01_1);
    step("b_c2b",   6'b1_0_1_01_1);
    step("b_c3b",   6'b0_0_1_01_1);
    step("b_c4",    6'b0_0_1_01_1);
    step("b_c5",    6'b0_0_1_01_1);
    step("b_wrap2", 6'b1_1_1_01_1);

    // sel=2 (odd div 5): 11000
    sel = 2'd2; sel_valid = 1'b1;
    step("c_acc",   6'b1_0_1_01_0);
    sel_valid = 1'b0;
    step("c_c2",    6'b1_0_1_01_0);
    step("c_c3",    6'b0_0_1_01_0);
    step("c_c4",    6'b0_0_1_01_0);
    step("c_c5",    6'b0_0_1_01_0);
    step("c_wrap",  6'b1_1_1_10_1);
    step("c5_c1",   6'b1_0_1_10_1);
    step("c5_c2",   6'b0_0_1_10_1);
    step("c5_c3",   6'b0_0_1_10_1);
    step("c5_c4",   6'b0_0_1_10_1);
    step("c5_wrap", 6'b1_1_1_10_1);

    // sel=3 (div 2): 10
    sel = 2'd3; sel_valid = 1'b1;
    step("c3_acc",  6'b1_0_1_10_0);
    sel_valid = 1'b0;
    step("c3_c2",   6'b0_0_1_10_0);
    step("c3_c3",   6'b0_0_1_10_0);
    step("c3_c4",   6'b0_0_1_10_0);
    step("d2_wrap", 6'b1_1_1_11_1);
    step("d2_c1",   6'b0_0_1_11_1);
    step("d2_wrp2", 6'b1_1_1_11_1);
    step("d2_c1b",  6'b0_0_1_11_1);

    // request accepted on a wrap edge applies only at the following wrap
    sel = 2'd0; sel_valid = 1'b1;
    step("wrap_acc", 6'b1_1_1_11_0);
    sel_valid = 1'b0;
    step("wa_c1",    6'b0_0_1_11_0);
    step("wa_apply", 6'b1_1_1_00_1);

    // drop enable at counter=1: period completes, then STOP
    step("d_c1",    6'b1_0_1_00_1);
    enable = 1'b0;
    step("d_c2",    6'b0_0_1_00_1);
    step("d_c3",    6'b0_0_1_00_1);
    step("d_stop",  6'b0_0_0_00_1);
    step("d_held",  6'b0_0_0_00_1);
    enable = 1'b1;
    step("d_restart", 6'b1_1_1_00_1);
    step("d_r1",    6'b1_0_1_00_1);
    enable = 1'b0;
    step("d_r2",    6'b0_0_1_00_1);
    step("d_r3",    6'b0_0_1_00_1);
    step("d_stop2", 6'b0_0_0_00_1);

    // in STOP a request applies next edge; ready stays high
    sel = 2'd1; sel_valid = 1'b1;
    step("e_stopsel", 6'b0_0_0_01_1);
    sel_valid = 1'b0;
    step("e_idle",  6'b0_0_0_01_1);
    enable = 1'b1;
    step("e_start", 6'b1_1_1_01_1);
    sel = 2'd2; sel_valid = 1'b1;
    step("e_acc1",  6'b1_0_1_01_0);
    sel = 2'd3;
    step("e_held",  6'b1_0_1_01_0);
    step("e_held3", 6'b0_0_1_01_0);
    step("e_held4", 6'b0_0_1_01_0);
    step("e_held5", 6'b0_0_1_01_0);
    step("e_wrap",  6'b1_1_1_10_1);
    step("e_acc2",  6'b1_0_1_10_0);
    sel_valid = 1'b0;
    step("e_c2",    6'b0_0_1_10_0);
    step("e_c3",    6'b0_0_1_10_0);
    step("e_c4",    6'b0_0_1_10_0);
    step("e_wrap2", 6'b1_1_1_11_1);

    // reset mid-period with a pending request
    sel = 2'd1; sel_valid = 1'b1;
    step("f_acc1",  6'b0_0_1_11_0);
    sel_valid = 1'b0;
    step("f_wrap",  6'b1_1_1_01_1);
    sel = 2'd2; sel_valid = 1'b1;
    step("f_acc2",  6'b1_0_1_01_0);
    sel_valid = 1'b0;
    step("f_c2",    6'b1_0_1_01_0);
    reset_n = 1'b0;
    #1;
    chk("f_async", obs, 6'b0_0_0_00_1);
    enable = 1'b0;
    @(negedge clock_in);
    chk("f_hold", obs, 6'b0_0_0_00_1);
    reset_n = 1'b1;
    step("f_idle",  6'b0_0_0_00_1);
    enable = 1'b1;
    step("f_start", 6'b1_1_1_00_1);
    step("f_c1",    6'b1_0_1_00_1);
    step("f_c2b",   6'b0_0_1_00_1);
    step("f_c3",    6'b0_0_1_00_1);
    step("f_div0",  6'b1_1_1_00_1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/clk_rate_sequencer.md
Name: clk_rate_sequencer

Overview:
- Runtime-selectable clock-divider controller: owns one divide counter and steps it through a 4-entry divisor table (11 Hz, 1 Hz, 2 Hz, 5 Hz at 100 MHz by default).
- Front-end logic requests rate changes over a valid/ready handshake. The block applies them only at a period boundary, so clock_out never produces a runt pulse.
- Provides start/stop with drain-to-boundary. Sits between the board clock and the display/LED scan logic that consumes clock_out or tick.

Parameters:
- CNT_W, 28, counter width.
- DIV0, 28'd9090909, divisor for sel=0 (11 Hz).
- DIV1, 28'd100000000, divisor for sel=1 (1 Hz).
- DIV2, 28'd50000000, divisor for sel=2 (2 Hz).
- DIV3, 28'd20000000, divisor for sel=3 (5 Hz).
- RESET_SEL, 2'd0, active_sel after reset.

Ports:
- clock_in  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  level; 1 = run, 0 = stop at next boundary.
- sel  in  2  requested divisor index.
- sel_valid  in  1  rate-change request.
- sel_ready  out  1  request can be accepted.
- clock_out  out  1  divided clock, nominal 50% duty.
- tick  out  1  one-cycle pulse at start of each period.
- active_sel  out  2  divisor index currently in use.
- running  out  1  1 while a period is in progress.

Behaviour:
- One clock: clock_in. Reset is asynchronous, active-low (reset_n). Every flop resets asynchronously; outputs are registered.
- Reset values: counter=0, state=STOP, clock_out=0, tick=0, running=0, active_sel=RESET_SEL, pending empty, sel_ready=1.
- Divisor rules:
  - div = table[active_sel]; half = div>>1.
  - All DIVn must be >=2; check at elaboration.
  - Odd div gives floor(div/2) cycles high and ceil(div/2) cycles low.
- States:
  - STOP: counter held at 0, clock_out=0, running=0. If enable=1, go to RUN; on that edge counter<=0, clock_out<=1, tick<=1, running<=1.
  - RUN: counter+1 each cycle. clock_out <= (counter_next < half). At counter==div-1 (wrap edge):
    - if enable=1: counter<=0, clock_out<=1, tick<=1.
    - if enable=0: go to STOP, clock_out<=0, tick<=0, running<=0.
  - tick=0 on every non-wrap edge.
  - enable=0 mid-period takes no immediate action; the period always completes. Re-asserting enable before the wrap cancels the stop.
- Handshake:
  - sel_ready = !pending_valid. Transfer happens when sel_valid && sel_ready. sel is ignored when sel_valid=0.
  - In STOP, an accepted sel updates active_sel on the next edge. Pending stays empty and sel_ready stays 1.
  - In RUN, an accepted sel is stored in pending and sel_ready drops the next cycle. At the next wrap edge, active_sel<=pending, the new period uses the new div, and pending clears.
  - A request accepted on the same edge as a wrap applies at the following wrap, not the current one.
  - Pending is applied on the stop wrap too: active_sel updates as the block enters STOP.
  - Same-edge STOP->RUN with a handshake: the new sel applies to the first period.
- Reset mid-operation: immediate return to reset values, pending discarded, clock_out low with no glitch hold.
- Width: counter compares use CNT_W unsigned. half is computed from the divisor of the current period, never mid-period.

Decomposition:
- Package clk_rate_pkg:
  - state enum {STOP, RUN} and SEL_W=2.
  - default divisor constants DIV_11HZ, DIV_1HZ, DIV_2HZ, DIV_5HZ.
  - function div_of(sel).
- Sub-module clk_div_core holds the counter and the clock_out/tick generation:
  - inputs div, run, load.
  - outputs wrap, clock_out, tick.
- The top level holds the FSM, the pending register and the handshake.

Test Plan (override DIV0=4, DIV1=6, DIV2=5, DIV3=2):
- Reset, enable=1 -> tick on the first RUN cycle, then every 4 cycles; clock_out pattern 1100 repeating; running=1.
- Running sel=0; sel=1 valid mid-period -> sel_ready=0 next cycle; current 4-cycle period completes; next period is 6 cycles (111000); active_sel=1 at that wrap; sel_ready=1 again.
- sel=2 (odd) -> pattern 11000, tick every 5 cycles. sel=3 -> pattern 10, tick every cycle-pair.
- enable dropped at counter=1 of a 4-cycle period -> clock_out finishes 1100, then STOP with clock_out=0 and running=0. Re-raise enable -> restart with tick=1.
- In STOP, sel=1 valid -> active_sel=1 the next cycle, sel_ready stays 1. A second request while running and pending is full is held off (sel_ready=0) until the wrap.
- Assert reset_n=0 at counter=2 with pending valid -> outputs go to reset values asynchronously; active_sel=RESET_SEL; pending lost.
